// File: rtl/mbox_ebox_responder.sv
// MBOX-side responder for EBOX memory requests: fixed-latency single-word
// store with non-existent-memory detection and read-pause-write support.
module mbox_ebox_responder #(
   parameter int unsigned ADDR_BITS = 14,
   parameter int unsigned MEM_WORDS = 16384,
   parameter int unsigned LATENCY   = 3
) (
   input  logic          mboxClk,
   input  logic          mboxReset,
   input  logic          EBOX_REQ,
   input  logic [13:35]  EBOX_VMA,
   input  logic          eboxRead,
   input  logic          eboxWrite,
   input  logic          eboxPSE,
   input  logic [0:35]   cacheDataWrite,
   output logic          mboxRespIn,
   output logic [0:35]   cacheDataRead,
   output logic          nxmErr,
   output logic          mboxBusy
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP, PAUSE} state_t;

   localparam logic [23:0] MEM_LIMIT = 24'(MEM_WORDS);
   localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);
   localparam state_t      FIRST_ST  = (LATENCY == 1) ? RESP : WAIT;

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q;
   logic [ADDR_BITS-1:0]   idx_q;
   logic                   nxm_q;
   logic                   rd_q, wr_q, pse_q;
   logic [0:35]            wdata_q;
   logic [0:35]            mem_q [0:(2**ADDR_BITS)-1];

   logic [ADDR_BITS-1:0]   idx_in, rd_idx;
   logic                   nxm_in, rd_nxm;
   logic                   fresh_accept, pause_write;

   // Request decode, next state and the address feeding the response read
   always_comb begin
      idx_in       = EBOX_VMA[36-ADDR_BITS:35];
      nxm_in       = ({1'b0, EBOX_VMA} >= MEM_LIMIT);
      fresh_accept = EBOX_REQ && (eboxRead || eboxWrite) &&
                     ((state_q == IDLE) || ((state_q == PAUSE) && !eboxWrite));
      pause_write  = EBOX_REQ && eboxWrite && (state_q == PAUSE);
      // With LATENCY=1 the response is produced on the accept edge, so the
      // read must use the incoming address rather than the latched one.
      rd_idx       = fresh_accept ? idx_in : idx_q;
      rd_nxm       = fresh_accept ? nxm_in : nxm_q;
      state_d      = state_q;
      case (state_q)
         IDLE:    if (fresh_accept) state_d = FIRST_ST;
         WAIT:    if (cnt_q == 4'd1) state_d = RESP;
         RESP:    state_d = (rd_q && pse_q && !wr_q && !nxm_q) ? PAUSE : IDLE;
         PAUSE:   if (fresh_accept || pause_write) state_d = FIRST_ST;
         default: state_d = IDLE;
      endcase
   end

   // Control FSM, request latch and registered response outputs
   always_ff @(posedge mboxClk) begin
      if (mboxReset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         idx_q         <= '0;
         nxm_q         <= 1'b0;
         rd_q          <= 1'b0;
         wr_q          <= 1'b0;
         pse_q         <= 1'b0;
         wdata_q       <= '0;
         mboxRespIn    <= 1'b0;
         cacheDataRead <= '0;
         nxmErr        <= 1'b0;
         mboxBusy      <= 1'b0;
      end else begin
         state_q       <= state_d;
         mboxRespIn    <= (state_d == RESP);
         nxmErr        <= (state_d == RESP) && rd_nxm;
         cacheDataRead <= ((state_d == RESP) && !rd_nxm) ? mem_q[rd_idx] : '0;
         mboxBusy      <= (state_d != IDLE);
         if (fresh_accept) begin
            idx_q   <= idx_in;
            nxm_q   <= nxm_in;
            rd_q    <= eboxRead;
            wr_q    <= eboxWrite;
            pse_q   <= eboxPSE;
            wdata_q <= cacheDataWrite;
            cnt_q   <= CNT_INIT;
         end else if (pause_write) begin
            // Follow-on write of a read-pause-write keeps the paused address.
            wdata_q <= cacheDataWrite;
            wr_q    <= 1'b1;
            pse_q   <= 1'b0;
            cnt_q   <= CNT_INIT;
         end else if (state_q == WAIT) begin
            cnt_q   <= cnt_q - 4'd1;
         end
      end
   end

   // Word store: commit on the edge that ends the response cycle; reset aborts it
   always_ff @(posedge mboxClk) begin
      if (!mboxReset && (state_q == RESP) && wr_q && !nxm_q)
         mem_q[idx_q] <= wdata_q;
   end

endmodule

// File: tb/tb_mbox_ebox_responder.sv
// Bench for mbox_ebox_responder: two builds (LATENCY=3 full store, LATENCY=1
// with MEM_WORDS below the index range) driven with identical stimulus and
// checked every cycle against a transaction-level model.
module tb_mbox_ebox_responder;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req = 1'b0, rd = 1'b0, wr = 1'b0, pse = 1'b0;
   logic [13:35]  vma = '0;
   logic [0:35]   wdat = '0;

   logic          resp [2];
   logic [35:0]   rdat [2];
   logic          nxm  [2];
   logic          busy [2];

   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   mbox_ebox_responder #(.ADDR_BITS(14), .MEM_WORDS(16384), .LATENCY(3)) dut0 (
      .mboxClk(clk), .mboxReset(rst), .EBOX_REQ(req), .EBOX_VMA(vma),
      .eboxRead(rd), .eboxWrite(wr), .eboxPSE(pse), .cacheDataWrite(wdat),
      .mboxRespIn(resp[0]), .cacheDataRead(rdat[0]), .nxmErr(nxm[0]), .mboxBusy(busy[0]));

   mbox_ebox_responder #(.ADDR_BITS(14), .MEM_WORDS(16000), .LATENCY(1)) dut1 (
      .mboxClk(clk), .mboxReset(rst), .EBOX_REQ(req), .EBOX_VMA(vma),
      .eboxRead(rd), .eboxWrite(wr), .eboxPSE(pse), .cacheDataWrite(wdat),
      .mboxRespIn(resp[1]), .cacheDataRead(rdat[1]), .nxmErr(nxm[1]), .mboxBusy(busy[1]));

   function automatic int lat_of(int d);
      return (d == 0) ? 3 : 1;
   endfunction

   function automatic bit is_nxm(int d, logic [22:0] a);
      return int'(a) >= ((d == 0) ? 16384 : 16000);
   endfunction

   function automatic int key_of(int d, logic [22:0] a);
      return d * 32'h100000 + int'(a[13:0]);
   endfunction

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%o expected=%o at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: one outstanding request, strobe LATENCY-1 edges after
   // accept, write committed one edge after the strobe.
   bit            m_out [2], m_paused [2], m_rd [2], m_wr [2], m_pse [2];
   int            m_due [2];
   logic [22:0]   m_vma [2];
   logic [35:0]   m_data [2];
   logic [35:0]   mmem [int];
   bit            e_resp [2], e_nxm [2], e_busy [2], e_known [2];
   logic [35:0]   e_dat [2];
   int            edge_n = 0;
   bit            chk_en = 0;

   task automatic model_step(input int d);
      bit was;
      if (rst) begin
         m_out[d] = 0; m_paused[d] = 0;
         e_resp[d] = 0; e_nxm[d] = 0; e_busy[d] = 0; e_dat[d] = '0; e_known[d] = 1;
         return;
      end
      was = m_out[d];
      if (was && edge_n == m_due[d] + 1) begin
         if (m_wr[d] && !is_nxm(d, m_vma[d])) mmem[key_of(d, m_vma[d])] = m_data[d];
         m_out[d]    = 0;
         m_paused[d] = m_rd[d] && m_pse[d] && !m_wr[d] && !is_nxm(d, m_vma[d]);
      end
      if (!was && req) begin
         if (m_paused[d] && wr) begin
            m_data[d] = wdat; m_wr[d] = 1; m_pse[d] = 0;
            m_paused[d] = 0; m_out[d] = 1; m_due[d] = edge_n + lat_of(d) - 1;
         end else if (rd || wr) begin
            m_vma[d] = vma; m_rd[d] = rd; m_wr[d] = wr; m_pse[d] = pse; m_data[d] = wdat;
            m_paused[d] = 0; m_out[d] = 1; m_due[d] = edge_n + lat_of(d) - 1;
         end
      end
      e_resp[d]  = m_out[d] && (edge_n == m_due[d]);
      e_nxm[d]   = e_resp[d] && is_nxm(d, m_vma[d]);
      e_busy[d]  = m_out[d] || m_paused[d];
      e_dat[d]   = '0;
      e_known[d] = 1;
      if (e_resp[d] && !e_nxm[d]) begin
         if (mmem.exists(key_of(d, m_vma[d]))) e_dat[d] = mmem[key_of(d, m_vma[d])];
         else e_known[d] = 0;
      end
   endtask

   // Compare process: advance the model on each edge and check both builds
   always begin
      @(posedge clk);
      #1;
      edge_n++;
      if (rst) chk_en = 1;
      for (int d = 0; d < 2; d++) model_step(d);
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_resp", d), 36'(resp[d]), 36'(e_resp[d]));
            chk($sformatf("d%0d_nxm", d),  36'(nxm[d]),  36'(e_nxm[d]));
            chk($sformatf("d%0d_busy", d), 36'(busy[d]), 36'(e_busy[d]));
            if (e_known[d]) chk($sformatf("d%0d_data", d), rdat[d], e_dat[d]);
         end
      end
   end

   task automatic do_req(input bit r, input bit w, input bit p, input logic [22:0] a,
                         input logic [35:0] dv, output logic [35:0] gd, output logic gn,
                         output int l0, output int l1);
      @(negedge clk);
      req = 1; rd = r; wr = w; pse = p; vma = a; wdat = dv;
      gd = '0; gn = 0; l0 = 0; l1 = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin req = 0; rd = 0; wr = 0; pse = 0; end
         if (resp[1] && l1 == 0) l1 = k;
         if (resp[0]) begin l0 = k; gd = rdat[0]; gn = nxm[0]; break; end
      end
   endtask

   logic [35:0] gd;
   logic        gn;
   int          l0, l1, cnt0, cnt1;

   initial begin
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_resp%0d", d), 36'(resp[d]), 36'd0);
         chk($sformatf("rst_busy%0d", d), 36'(busy[d]), 36'd0);
         chk($sformatf("rst_data%0d", d), rdat[d], 36'd0);
         chk($sformatf("rst_nxm%0d", d),  36'(nxm[d]),  36'd0);
      end
      rst = 0;

      do_req(0, 1, 0, 23'o100, 36'o123456701234, gd, gn, l0, l1);
      chk("wr_lat3", 36'(l0), 36'd3);
      chk("wr_lat1", 36'(l1), 36'd1);
      do_req(1, 0, 0, 23'o100, 36'o0, gd, gn, l0, l1);
      chk("rd_lat", 36'(l0), 36'd3);
      chk("rd_data", gd, 36'o123456701234);
      chk("rd_nxm", 36'(gn), 36'd0);

      do_req(1, 0, 0, 23'o40000, 36'o0, gd, gn, l0, l1);
      chk("nxm_data", gd, 36'd0);
      chk("nxm_flag", 36'(gn), 36'd1);

      do_req(0, 1, 0, 23'o200, 36'd5, gd, gn, l0, l1);
      do_req(0, 1, 0, 23'o300, 36'o777, gd, gn, l0, l1);
      do_req(1, 0, 1, 23'o200, 36'o0, gd, gn, l0, l1);
      chk("rpw_rd_data", gd, 36'd5);
      @(negedge clk);
      chk("rpw_busy", 36'(busy[0]), 36'd1);
      do_req(0, 1, 0, 23'o300, 36'd7, gd, gn, l0, l1);
      chk("rpw_wr_lat", 36'(l0), 36'd3);
      chk("rpw_wr_data", gd, 36'd5);
      do_req(1, 0, 0, 23'o200, 36'o0, gd, gn, l0, l1);
      chk("rpw_after200", gd, 36'd7);
      do_req(1, 0, 0, 23'o300, 36'o0, gd, gn, l0, l1);
      chk("rpw_after300", gd, 36'o777);

      do_req(0, 1, 0, 23'o10, 36'd1, gd, gn, l0, l1);
      @(negedge clk);
      req = 1; rd = 0; wr = 1; pse = 0; vma = 23'o10; wdat = 36'd99;
      @(negedge clk);
      req = 0; wr = 0; rst = 1;
      @(negedge clk);
      rst = 0;
      chk("abort_resp", 36'(resp[0]), 36'd0);
      chk("abort_busy", 36'(busy[0]), 36'd0);
      chk("abort_data", rdat[0], 36'd0);
      do_req(1, 0, 0, 23'o10, 36'o0, gd, gn, l0, l1);
      chk("abort_keep", gd, 36'd1);

      @(negedge clk);
      req = 1; rd = 1; wr = 0; pse = 0; vma = 23'o100;
      cnt0 = 0; cnt1 = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (resp[0]) cnt0++;
         if (resp[1]) cnt1++;
      end
      req = 0; rd = 0;
      repeat (3) @(negedge clk);
      chk("b2b_strobes3", 36'(cnt0), 36'd3);
      chk("b2b_strobes1", 36'(cnt1), 36'd6);

      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         rst  = ($urandom_range(0, 199) == 0);
         req  = $urandom_range(0, 1) == 1;
         rd   = $urandom_range(0, 1) == 1;
         wr   = $urandom_range(0, 1) == 1;
         pse  = $urandom_range(0, 1) == 1;
         wdat = {4'($urandom), $urandom};
         case ($urandom_range(0, 11))
            0:       vma = 23'o100;
            1:       vma = 23'o200;
            2:       vma = 23'o300;
            3:       vma = 23'o10;
            4:       vma = 23'd16383;
            5:       vma = 23'd16384;
            6:       vma = 23'd15999;
            7:       vma = 23'd16000;
            8:       vma = 23'h400005;
            9:       vma = 23'h7fffff;
            default: vma = 23'($urandom_range(0, 15));
         endcase
      end
      @(negedge clk);
      rst = 0; req = 0; rd = 0; wr = 0; pse = 0;
      repeat (6) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
